// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller:
// FSM states, ARM instruction classes and field positions.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LDST   = 3'b010;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    localparam int CLS_MSB = 27;
    localparam int CLS_LSB = 25;
    localparam int L_BIT   = 20;

    function automatic logic [2:0] inst_class(input logic [31:0] inst);
        return inst[CLS_MSB:CLS_LSB];
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in MEM whose destination
// feeds a register source of the instruction currently in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [2:0] ex_cls_i,
    input  logic       ex_valid_i,
    input  logic [3:0] ex_r1_addr_i,
    input  logic [3:0] ex_r2_addr_i,
    input  logic [2:0] mem_cls_i,
    input  logic       mem_l_i,
    input  logic [3:0] mem_rd_addr_i,
    input  logic       mem_valid_i,
    output logic       hazard_o
);

    logic w_is_load;
    logic w_rm_hit;
    logic w_rn_hit;
    logic w_src_hit;

    assign w_is_load = mem_valid_i & mem_l_i & (mem_cls_i == CLS_LDST);
    assign w_rm_hit  = (ex_r1_addr_i == mem_rd_addr_i);
    assign w_rn_hit  = (ex_r2_addr_i == mem_rd_addr_i);

    // Immediate and load/store forms only read Rn; register DP reads both.
    always_comb begin
        w_src_hit = 1'b0;
        unique case (ex_cls_i)
            CLS_DP_REG: w_src_hit = w_rm_hit | w_rn_hit;
            CLS_DP_IMM: w_src_hit = w_rn_hit;
            CLS_LDST:   w_src_hit = w_rn_hit;
            default:    w_src_hit = 1'b0;
        endcase
    end

    assign hazard_o = w_is_load & ex_valid_i & w_src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch squash window, memory-busy freeze and saturating perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      ex_inst_i,
    input  logic             ex_valid_i,
    input  logic [3:0]       ex_r1_addr_i,
    input  logic [3:0]       ex_r2_addr_i,
    input  logic [31:0]      mem_inst_i,
    input  logic [3:0]       mem_rd_addr_i,
    input  logic             mem_valid_i,
    input  logic             branch_i,
    input  logic             mem_busy_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             bubble_ex_o,
    output logic             flush_id_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam state_t ST_AFTER_BR = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    state_t            r_state;
    state_t            r_saved;
    logic [FC_W-1:0]   r_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    state_t            w_next;
    state_t            w_saved_next;
    logic [FC_W-1:0]   w_cnt_next;
    logic              w_hazard;
    logic              w_branch;
    logic              w_stall_all;
    logic              w_pc_en;
    logic              w_if_id_en;
    logic              w_id_ex_en;
    logic              w_ex_mem_en;
    logic              w_bubble;
    logic              w_flush;
    logic              w_flush_inc;
    logic              w_unused;

    assign w_unused = &{1'b0, ex_inst_i[31:28], ex_inst_i[24:0],
                        mem_inst_i[31:28], mem_inst_i[24:21],
                        mem_inst_i[19:0]};

    hazard_detect u_hazard_detect (
        .ex_cls_i      (inst_class(ex_inst_i)),
        .ex_valid_i    (ex_valid_i),
        .ex_r1_addr_i  (ex_r1_addr_i),
        .ex_r2_addr_i  (ex_r2_addr_i),
        .mem_cls_i     (inst_class(mem_inst_i)),
        .mem_l_i       (mem_inst_i[L_BIT]),
        .mem_rd_addr_i (mem_rd_addr_i),
        .mem_valid_i   (mem_valid_i),
        .hazard_o      (w_hazard)
    );

    assign w_branch = branch_i & ex_valid_i;

    always_comb begin
        w_next       = r_state;
        w_saved_next = r_saved;
        w_cnt_next   = r_cnt;
        w_stall_all  = 1'b0;
        w_pc_en      = 1'b1;
        w_if_id_en   = 1'b1;
        w_id_ex_en   = 1'b1;
        w_ex_mem_en  = 1'b1;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        w_flush_inc  = 1'b0;
        unique case (r_state)
            ST_RUN, ST_LDUSE: begin
                if (mem_busy_i) begin
                    w_stall_all  = 1'b1;
                    w_saved_next = ST_RUN;
                    w_next       = ST_MEMWAIT;
                end else if (w_branch) begin
                    w_flush     = 1'b1;
                    w_flush_inc = 1'b1;
                    w_cnt_next  = FC_LOAD;
                    w_next      = ST_AFTER_BR;
                end else if (w_hazard && r_state == ST_RUN) begin
                    w_pc_en    = 1'b0;
                    w_if_id_en = 1'b0;
                    w_id_ex_en = 1'b0;
                    w_bubble   = 1'b1;
                    w_next     = ST_LDUSE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (mem_busy_i) begin
                    w_stall_all  = 1'b1;
                    w_saved_next = ST_FLUSH;
                    w_next       = ST_MEMWAIT;
                end else if (w_branch) begin
                    w_flush     = 1'b1;
                    w_flush_inc = 1'b1;
                    w_cnt_next  = FC_LOAD;
                    w_next      = ST_AFTER_BR;
                end else begin
                    // cnt holds the squash cycles still owed, this one included
                    w_flush = 1'b1;
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - FC_W'(1);
                    end
                    if (r_cnt <= FC_W'(1)) begin
                        w_next = ST_RUN;
                    end
                end
            end
            ST_MEMWAIT: begin
                w_stall_all = 1'b1;
                if (!mem_busy_i) begin
                    w_next = r_saved;
                end
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_RUN;
            r_saved     <= ST_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_saved <= w_saved_next;
            r_cnt   <= w_cnt_next;
            if (!pc_en_o && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // Reset overrides the FSM outputs combinationally, not just at the edge.
    assign pc_en_o     = w_pc_en     & ~w_stall_all & ~reset_i;
    assign if_id_en_o  = w_if_id_en  & ~w_stall_all & ~reset_i;
    assign id_ex_en_o  = w_id_ex_en  & ~w_stall_all & ~reset_i;
    assign ex_mem_en_o = w_ex_mem_en & ~w_stall_all & ~reset_i;
    assign bubble_ex_o = w_bubble & ~reset_i;
    assign flush_id_o  = w_flush | reset_i;
    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle reference model
// plus hand-computed expectations for each scenario.
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;
    localparam int CW = 16;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [31:0] I_LDR3 = 32'hE5903000;
    localparam logic [31:0] I_STR3 = 32'hE5803000;
    localparam logic [31:0] I_ADD  = 32'hE0834005;
    localparam logic [31:0] I_ADDI = 32'hE2834001;
    localparam logic [31:0] I_LDRN = 32'hE5932000;
    localparam logic [31:0] I_BR   = 32'hEA000000;
    localparam logic [31:0] I_NOP  = 32'hE1A00000;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [31:0]   ex_inst_i = '0;
    logic          ex_valid_i = 1'b0;
    logic [3:0]    ex_r1_addr_i = '0;
    logic [3:0]    ex_r2_addr_i = '0;
    logic [31:0]   mem_inst_i = '0;
    logic [3:0]    mem_rd_addr_i = '0;
    logic          mem_valid_i = 1'b0;
    logic          branch_i = 1'b0;
    logic          mem_busy_i = 1'b0;
    logic          pc_en_o;
    logic          if_id_en_o;
    logic          id_ex_en_o;
    logic          ex_mem_en_o;
    logic          bubble_ex_o;
    logic          flush_id_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) u_dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .ex_inst_i     (ex_inst_i),
        .ex_valid_i    (ex_valid_i),
        .ex_r1_addr_i  (ex_r1_addr_i),
        .ex_r2_addr_i  (ex_r2_addr_i),
        .mem_inst_i    (mem_inst_i),
        .mem_rd_addr_i (mem_rd_addr_i),
        .mem_valid_i   (mem_valid_i),
        .branch_i      (branch_i),
        .mem_busy_i    (mem_busy_i),
        .pc_en_o       (pc_en_o),
        .if_id_en_o    (if_id_en_o),
        .id_ex_en_o    (id_ex_en_o),
        .ex_mem_en_o   (ex_mem_en_o),
        .bubble_ex_o   (bubble_ex_o),
        .flush_id_o    (flush_id_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: the pipe is either frozen, owes squash cycles,
    // has just inserted a load-use bubble, or is running freely.
    bit m_frozen = 1'b0;
    bit m_shadow = 1'b0;
    int m_squash = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic bit ref_load_use();
        bit ld;
        bit rm;
        bit rn;
        ld = mem_valid_i && mem_inst_i[27:25] == 3'b010 && mem_inst_i[20];
        rm = ex_r1_addr_i == mem_rd_addr_i;
        rn = ex_r2_addr_i == mem_rd_addr_i;
        if (!ld || !ex_valid_i) return 1'b0;
        if (ex_inst_i[27:25] == 3'b000) return rm || rn;
        if (ex_inst_i[27:25] == 3'b001) return rn;
        if (ex_inst_i[27:25] == 3'b010) return rn;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        bit e_pc;
        bit e_en;
        bit e_bub;
        bit e_fl;
        int e_st;
        bit br;
        bit hz;
        br = branch_i && ex_valid_i;
        hz = ref_load_use();
        e_pc = 1'b1;
        e_en = 1'b1;
        e_bub = 1'b0;
        e_fl = 1'b0;
        if (reset_i) begin
            m_frozen = 1'b0;
            m_shadow = 1'b0;
            m_squash = 0;
            m_stall = 0;
            m_flush = 0;
            e_st = 0;
            e_pc = 1'b0;
            e_en = 1'b0;
            e_fl = 1'b1;
        end else begin
            e_st = m_frozen ? 3 : (m_squash > 0) ? 2 : m_shadow ? 1 : 0;
            if (m_frozen || mem_busy_i) begin
                e_pc = 1'b0;
                e_en = 1'b0;
            end else if (br || m_squash > 0) begin
                e_fl = 1'b1;
            end else if (hz && !m_shadow) begin
                e_pc = 1'b0;
                e_bub = 1'b1;
            end
        end
        check("m_state", 32'(state_o), 32'(e_st));
        check("m_pc_en", 32'(pc_en_o), 32'(e_pc));
        check("m_if_id_en", 32'(if_id_en_o), 32'(e_pc));
        check("m_id_ex_en", 32'(id_ex_en_o), 32'(e_pc));
        check("m_ex_mem_en", 32'(ex_mem_en_o), 32'(e_en));
        check("m_bubble", 32'(bubble_ex_o), 32'(e_bub));
        check("m_flush", 32'(flush_id_o), 32'(e_fl));
        check("m_stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
        check("m_flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
        if (!reset_i) begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (m_frozen) begin
                if (!mem_busy_i) m_frozen = 1'b0;
            end else if (mem_busy_i) begin
                m_frozen = 1'b1;
                m_shadow = 1'b0;
            end else if (br) begin
                m_squash = FC - 1;
                m_shadow = 1'b0;
                if (m_flush < CMAX) m_flush++;
            end else if (m_squash > 0) begin
                m_squash--;
            end else begin
                m_shadow = hz && !m_shadow;
            end
        end
    end

    task automatic cyc(input logic exv, input logic [31:0] exi,
                       input logic [3:0] r1, input logic [3:0] r2,
                       input logic memv, input logic [31:0] mi,
                       input logic [3:0] mrd, input logic br,
                       input logic busy);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        ex_valid_i = exv;
        ex_inst_i = exi;
        ex_r1_addr_i = r1;
        ex_r2_addr_i = r2;
        mem_valid_i = memv;
        mem_inst_i = mi;
        mem_rd_addr_i = mrd;
        branch_i = br;
        mem_busy_i = busy;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, I_NOP, 4'd0, 4'd0, 1'b0, I_NOP, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic ldu(input logic br, input logic busy);
        cyc(1'b1, I_ADD, 4'd5, 4'd3, 1'b1, I_LDR3, 4'd3, br, busy);
    endtask

    task automatic take_br(input logic busy);
        cyc(1'b1, I_BR, 4'd0, 4'd0, 1'b0, I_NOP, 4'd0, 1'b1, busy);
    endtask

    task automatic busy_cyc();
        cyc(1'b0, I_NOP, 4'd0, 4'd0, 1'b0, I_NOP, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_pc_en", 32'(pc_en_o), 32'd0);
        check("rst_flush", 32'(flush_id_o), 32'd1);

        // 1: load-use bubble then one LDUSE cycle
        ldu(1'b0, 1'b0);
        check("t1_pc_en", 32'(pc_en_o), 32'd0);
        check("t1_bubble", 32'(bubble_ex_o), 32'd1);
        check("t1_ex_mem_en", 32'(ex_mem_en_o), 32'd1);
        ldu(1'b0, 1'b0);
        check("t1_state_ld", 32'(state_o), 32'd1);
        check("t1_pc_en2", 32'(pc_en_o), 32'd1);
        check("t1_bubble2", 32'(bubble_ex_o), 32'd0);
        check("t1_stall", 32'(stall_cnt_o), 32'd1);
        idle();
        check("t1_state_run", 32'(state_o), 32'd0);

        // 2: branch squash window and restart
        do_reset();
        take_br(1'b0);
        check("t2_flush0", 32'(flush_id_o), 32'd1);
        idle();
        check("t2_state_fl", 32'(state_o), 32'd2);
        check("t2_flush1", 32'(flush_id_o), 32'd1);
        check("t2_fcnt1", 32'(flush_cnt_o), 32'd1);
        idle();
        check("t2_state_run", 32'(state_o), 32'd0);
        check("t2_flush_off", 32'(flush_id_o), 32'd0);
        take_br(1'b0);
        take_br(1'b0);
        check("t2_restart_st", 32'(state_o), 32'd2);
        idle();
        check("t2_fcnt3", 32'(flush_cnt_o), 32'd3);
        check("t2_flush_rs", 32'(flush_id_o), 32'd1);
        idle();
        check("t2_state_end", 32'(state_o), 32'd0);

        // 3: memory busy in the middle of the squash window
        do_reset();
        take_br(1'b0);
        busy_cyc();
        check("t3_fl_busy_pc", 32'(pc_en_o), 32'd0);
        busy_cyc();
        check("t3_memwait", 32'(state_o), 32'd3);
        busy_cyc();
        idle();
        check("t3_memwait_en", 32'(ex_mem_en_o), 32'd0);
        idle();
        check("t3_resume", 32'(state_o), 32'd2);
        check("t3_resume_fl", 32'(flush_id_o), 32'd1);
        check("t3_stall", 32'(stall_cnt_o), 32'd4);
        idle();
        check("t3_run", 32'(state_o), 32'd0);

        // 4: branch beats load-use; busy beats both
        do_reset();
        ldu(1'b1, 1'b0);
        check("t4_br_flush", 32'(flush_id_o), 32'd1);
        check("t4_no_bubble", 32'(bubble_ex_o), 32'd0);
        check("t4_pc_en", 32'(pc_en_o), 32'd1);
        idle();
        idle();
        ldu(1'b1, 1'b1);
        check("t4_busy_pc", 32'(pc_en_o), 32'd0);
        idle();
        check("t4_memwait", 32'(state_o), 32'd3);
        check("t4_fcnt", 32'(flush_cnt_o), 32'd1);
        idle();
        check("t4_run", 32'(state_o), 32'd0);

        // 5: source-match rules per EX class
        do_reset();
        cyc(1'b1, I_ADDI, 4'd3, 4'd5, 1'b1, I_LDR3, 4'd3, 1'b0, 1'b0);
        check("t5_imm_rm", 32'(pc_en_o), 32'd1);
        cyc(1'b1, I_BR, 4'd3, 4'd3, 1'b1, I_LDR3, 4'd3, 1'b0, 1'b0);
        check("t5_branch_cls", 32'(pc_en_o), 32'd1);
        cyc(1'b1, I_ADD, 4'd5, 4'd3, 1'b1, I_STR3, 4'd3, 1'b0, 1'b0);
        check("t5_store", 32'(pc_en_o), 32'd1);
        cyc(1'b1, I_LDRN, 4'd0, 4'd3, 1'b1, I_LDR3, 4'd3, 1'b0, 1'b0);
        check("t5_ldst_rn", 32'(bubble_ex_o), 32'd1);
        cyc(1'b1, I_ADD, 4'd3, 4'd7, 1'b1, I_LDR3, 4'd3, 1'b0, 1'b0);
        check("t5_masked", 32'(bubble_ex_o), 32'd0);
        idle();
        cyc(1'b1, I_ADD, 4'd3, 4'd7, 1'b0, I_LDR3, 4'd3, 1'b0, 1'b0);
        check("t5_mem_inval", 32'(pc_en_o), 32'd1);

        // 6: reset in the middle of a memory wait
        do_reset();
        take_br(1'b0);
        busy_cyc();
        busy_cyc();
        check("t6_pre_state", 32'(state_o), 32'd3);
        check("t6_pre_stall", 32'(stall_cnt_o), 32'd1);
        do_reset();
        check("t6_state", 32'(state_o), 32'd0);
        check("t6_stall", 32'(stall_cnt_o), 32'd0);
        check("t6_fcnt", 32'(flush_cnt_o), 32'd0);
        check("t6_en", 32'(ex_mem_en_o), 32'd0);
        check("t6_flush", 32'(flush_id_o), 32'd1);
        idle();
        check("t6_run", 32'(state_o), 32'd0);
        check("t6_run_pc", 32'(pc_en_o), 32'd1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
